// File: rtl/serializer_tx.sv
// Transmit serializer: accepts a parallel word over valid/ready, waits for the
// receiver's status, then shifts it out LSB-first with a programmable strobe.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | ready for a new word; ready_out=1, busy_out=0
// WAIT_STATUS | word latched, waiting for status_in=1 (sampled as a level)
// GAP         | start gap countdown before the first strobe
// STROBE_H    | write_out high for HIGH_CYCLES with the current bit on data_out
// STROBE_L    | write_out low for LOW_CYCLES, data_out still holds the bit
module serializer_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int START_GAP   = 10,
    parameter int HIGH_CYCLES = 10,
    parameter int LOW_CYCLES  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  status_in,
    output logic                  data_out,
    output logic                  write_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int MAX_HL  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int MAX_ALL = (START_GAP > MAX_HL) ? START_GAP : MAX_HL;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int BC_W    = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(START_GAP - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_STATUS = 3'd1,
        GAP         = 3'd2,
        STROBE_H    = 3'd3,
        STROBE_L    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  ready_q, ready_d;
    logic                  data_q, data_d;
    logic                  write_q, write_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // One down-counter serves the start gap and both strobe phases.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ready_d   = ready_q;
        data_d    = data_q;
        write_d   = write_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        shifted   = shift_q >> 1;

        case (state_q)
            IDLE: begin
                if (valid_in && ready_q) begin
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = WAIT_STATUS;
                end
            end
            WAIT_STATUS: begin
                if (status_in) begin
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    data_d  = shift_q[0];
                    write_d = 1'b1;
                    cnt_d   = HIGH_LOAD;
                    state_d = STROBE_H;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE_H: begin
                if (cnt_q == '0) begin
                    write_d = 1'b0;
                    cnt_d   = LOW_LOAD;
                    state_d = STROBE_L;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE_L: begin
                if (cnt_q == '0) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        data_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        data_d    = shifted[0];
                        write_d   = 1'b1;
                        cnt_d     = HIGH_LOAD;
                        state_d   = STROBE_H;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ready_q   <= 1'b1;
            data_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready_out = ready_q;
    assign data_out  = data_q;
    assign write_out = write_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;

endmodule
